// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I main control FSM with retired-instruction counter
// Define MULTICYCLE_TRAP_EN to turn illegal opcodes into a sticky TRAP state.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [6:0]       opcode_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             iord_o,
   output logic             ir_write_o,
   output logic             pc_write_o,
   output logic             pc_src_o,
   output logic [1:0]       alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic             reg_write_o,
   output logic [1:0]       mem_to_reg_o,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retired_o,
   output logic             trap_o
);

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_EXEC_R    = 4'd6;
   localparam logic [3:0] S_EXEC_I    = 4'd7;
   localparam logic [3:0] S_ALU_WB    = 4'd8;
   localparam logic [3:0] S_BRANCH    = 4'd9;
   localparam logic [3:0] S_JAL       = 4'd10;
   localparam logic [3:0] S_TRAP      = 4'd11;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [3:0]       state;
   logic [3:0]       state_nxt;
   logic             retire;
   logic [CNT_W-1:0] retired;

   always_comb begin
      state_nxt = S_FETCH;
      retire    = 1'b0;
      case (state)
         S_FETCH:     state_nxt = mem_ready_i ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode_i)
               OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
               OP_R:              state_nxt = S_EXEC_R;
               OP_I:              state_nxt = S_EXEC_I;
               OP_BRANCH:         state_nxt = S_BRANCH;
               OP_JAL:            state_nxt = S_JAL;
`ifdef MULTICYCLE_TRAP_EN
               default:           state_nxt = S_TRAP;
`else
               default:           state_nxt = S_FETCH;
`endif
            endcase
         end
         S_MEM_ADDR:  state_nxt = (opcode_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_nxt = mem_ready_i ? S_MEM_WB : S_MEM_READ;
         S_MEM_WRITE: begin
            state_nxt = mem_ready_i ? S_FETCH : S_MEM_WRITE;
            retire    = mem_ready_i;
         end
         S_EXEC_R, S_EXEC_I: state_nxt = S_ALU_WB;
         S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
`ifdef MULTICYCLE_TRAP_EN
         S_TRAP:      state_nxt = S_TRAP;
`endif
         default:     state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= S_FETCH;
         retired <= '0;
      end else begin
         state <= state_nxt;
         if (retire)
            retired <= retired + CNT_W'(1);
      end
   end

   // Outputs are gated by rst_i so a reset mid-access drops requests without waiting for a clock.
   always_comb begin
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      iord_o       = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = 1'b0;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 2'b00;
      reg_write_o  = 1'b0;
      mem_to_reg_o = 2'b00;
      if (!rst_i) begin
         case (state)
            S_FETCH: begin
               mem_read_o  = 1'b1;
               alu_src_b_o = 2'b01;
               ir_write_o  = mem_ready_i;
               pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
               alu_src_a_o = 2'b10;
               alu_src_b_o = 2'b10;
            end
            S_MEM_ADDR: begin
               alu_src_a_o = 2'b01;
               alu_src_b_o = 2'b10;
            end
            S_MEM_READ: begin
               mem_read_o = 1'b1;
               iord_o     = 1'b1;
            end
            S_MEM_WB: begin
               reg_write_o  = 1'b1;
               mem_to_reg_o = 2'b01;
            end
            S_MEM_WRITE: begin
               mem_write_o = 1'b1;
               iord_o      = 1'b1;
            end
            S_EXEC_R: begin
               alu_src_a_o = 2'b01;
               alu_op_o    = 2'b10;
            end
            S_EXEC_I: begin
               alu_src_a_o = 2'b01;
               alu_src_b_o = 2'b10;
               alu_op_o    = 2'b10;
            end
            S_ALU_WB:    reg_write_o = 1'b1;
            S_BRANCH: begin
               alu_src_a_o = 2'b01;
               alu_op_o    = 2'b01;
               pc_src_o    = 1'b1;
               pc_write_o  = zero_i;
            end
            S_JAL: begin
               reg_write_o  = 1'b1;
               mem_to_reg_o = 2'b10;
               pc_write_o   = 1'b1;
               pc_src_o     = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef MULTICYCLE_TRAP_EN
   assign trap_o = (state == S_TRAP) && !rst_i;
`else
   assign trap_o = 1'b0;
`endif

   assign state_o   = state;
   assign retired_o = retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven scoreboard bench for multicycle_ctrl
// Build with MULTICYCLE_TRAP_EN defined to exercise the sticky trap path.
module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic [6:0]       opcode_i = 7'd0;
   logic             zero_i = 1'b0;
   logic             mem_ready_i = 1'b0;
   logic             mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_src_o;
   logic [1:0]       alu_src_a_o, alu_src_b_o, alu_op_o, mem_to_reg_o;
   logic             reg_write_o, trap_o;
   logic [3:0]       state_o;
   logic [CNT_W-1:0] retired_o;

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
      .mem_ready_i(mem_ready_i), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .iord_o(iord_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
      .pc_src_o(pc_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
      .alu_op_o(alu_op_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
      .state_o(state_o), .retired_o(retired_o), .trap_o(trap_o)
   );

   always #5 clk = ~clk;

   // path holds up to 8 state nibbles read left to right; rdy bit 7 is the first cycle.
   typedef struct packed {
      logic [6:0]  opcode;
      logic        zero;
      logic [3:0]  len;
      logic [31:0] path;
      logic [7:0]  rdy;
      logic        ret;
   } vec_t;

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] outs;
   } exp_t;

   vec_t       vecs [0:8];
   exp_t       sb [$];
   int         errors = 0;
   int         checks = 0;
   logic [3:0] exp_ret = 4'd0;

   function automatic logic [15:0] exp_outs(input logic [3:0] st, input logic rdy, input logic z);
      logic mr, mw, io, irw, pcw, pcs, rw, tr;
      logic [1:0] a, b, op, m2r;
      {mr, mw, io, irw, pcw, pcs, rw, tr} = 8'd0;
      {a, b, op, m2r} = 8'd0;
      case (st)
         4'd0:  begin mr = 1'b1; b = 2'b01; irw = rdy; pcw = rdy; end
         4'd1:  begin a = 2'b10; b = 2'b10; end
         4'd2:  begin a = 2'b01; b = 2'b10; end
         4'd3:  begin mr = 1'b1; io = 1'b1; end
         4'd4:  begin rw = 1'b1; m2r = 2'b01; end
         4'd5:  begin mw = 1'b1; io = 1'b1; end
         4'd6:  begin a = 2'b01; op = 2'b10; end
         4'd7:  begin a = 2'b01; b = 2'b10; op = 2'b10; end
         4'd8:  rw = 1'b1;
         4'd9:  begin a = 2'b01; op = 2'b01; pcs = 1'b1; pcw = z; end
         4'd10: begin rw = 1'b1; m2r = 2'b10; pcw = 1'b1; pcs = 1'b1; end
`ifdef MULTICYCLE_TRAP_EN
         4'd11: tr = 1'b1;
`endif
         default: ;
      endcase
      return {mr, mw, io, irw, pcw, pcs, a, b, op, rw, m2r, tr};
   endfunction

   function automatic logic [15:0] dut_outs();
      return {mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_src_o,
              alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o, mem_to_reg_o, trap_o};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_cycle(input logic [3:0] st, input logic [6:0] op, input logic z,
                              input logic rdy);
      exp_t e;
      opcode_i    = op;
      zero_i      = z;
      mem_ready_i = rdy;
      sb.push_back('{st: st, outs: exp_outs(st, rdy, z)});
      @(negedge clk);
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check($sformatf("state(exp %0d)", e.st), 32'(state_o), 32'(e.st));
         check($sformatf("outs(st %0d)", e.st), 32'(dut_outs()), 32'(e.outs));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      for (int i = 0; i < int'(v.len); i++)
         drive_cycle(v.path[31-4*i -: 4], v.opcode, v.zero, v.rdy[7-i]);
      exp_ret = exp_ret + 4'(v.ret);
      check("retired", 32'(retired_o), 32'(exp_ret));
      check("end_state", 32'(state_o), 32'd0);
   endtask

   task automatic apply_reset();
      rst_i       = 1'b1;
      mem_ready_i = 1'b0;
      exp_ret     = 4'd0;
      #1;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_outs", 32'(dut_outs()), 32'd0);
      check("rst_retired", 32'(retired_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{7'b0110011, 1'b0, 4'd4, 32'h0168_0000, 8'b1111_1111, 1'b1};
      vecs[1] = '{7'b0000011, 1'b0, 4'd8, 32'h0123_3334, 8'b1110_0011, 1'b1};
      vecs[2] = '{7'b1100011, 1'b1, 4'd3, 32'h0190_0000, 8'b1111_1111, 1'b1};
      vecs[3] = '{7'b1100011, 1'b0, 4'd3, 32'h0190_0000, 8'b1111_1111, 1'b1};
      vecs[4] = '{7'b0100011, 1'b0, 4'd4, 32'h0125_0000, 8'b1111_1111, 1'b1};
      vecs[5] = '{7'b0010011, 1'b0, 4'd4, 32'h0178_0000, 8'b1111_1111, 1'b1};
      vecs[6] = '{7'b1101111, 1'b0, 4'd3, 32'h01A0_0000, 8'b1111_1111, 1'b1};
      vecs[7] = '{7'b0000011, 1'b0, 4'd6, 32'h0012_3400, 8'b0111_1100, 1'b1};
      vecs[8] = '{7'b0100011, 1'b0, 4'd6, 32'h0125_5500, 8'b1110_0100, 1'b1};

      apply_reset();
      for (int i = 0; i < 9; i++)
         run_vec(vecs[i]);

      // Reset while a store is waiting in MEM_WRITE must kill the write at once.
      drive_cycle(4'd0, 7'b0100011, 1'b0, 1'b1);
      drive_cycle(4'd1, 7'b0100011, 1'b0, 1'b1);
      drive_cycle(4'd2, 7'b0100011, 1'b0, 1'b1);
      mem_ready_i = 1'b0;
      #2;
      check("store_mem_write", 32'(mem_write_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check("async_mem_write", 32'(mem_write_o), 32'd0);
      check("async_state", 32'(state_o), 32'd0);
      check("async_retired", 32'(retired_o), 32'd0);
      apply_reset();

      run_vec(vecs[0]);
      drive_cycle(4'd0, 7'b1111111, 1'b0, 1'b1);
      drive_cycle(4'd1, 7'b1111111, 1'b0, 1'b1);
`ifdef MULTICYCLE_TRAP_EN
      for (int i = 0; i < 20; i++)
         drive_cycle(4'd11, 7'b1111111, 1'b0, 1'b1);
      check("trap_retired", 32'(retired_o), 32'(exp_ret));
      apply_reset();
`else
      check("nop_retired", 32'(retired_o), 32'(exp_ret));
      check("nop_state", 32'(state_o), 32'd0);
`endif
      run_vec(vecs[5]);

      apply_reset();
      for (int i = 0; i < 15; i++)
         run_vec(vecs[0]);
      check("retired_15", 32'(retired_o), 32'd15);
      run_vec(vecs[0]);
      check("retired_wrap", 32'(retired_o), 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
